// File: rtl/ds_sample_feeder.sv
// Input sequencer for delta_sigma_pw_modulator: a sample FIFO plus an IDLE/PRIME/RUN FSM
// that holds each sample on u for osr+1 modulator periods.
module ds_sample_feeder #(
  parameter int IN_BITS    = 16,
  parameter int DEPTH      = 4,
  parameter int OSR_BITS   = 8,
  parameter int LEVEL_BITS = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [OSR_BITS-1:0]   osr,
  input  logic [LEVEL_BITS-1:0] prime_level,
  input  logic                  underrun_zero,
  input  logic                  clear_status,
  input  logic                  in_valid,
  input  logic [IN_BITS-1:0]    in_data,
  output logic                  in_ready,
  input  logic                  pulse_done,
  output logic [IN_BITS-1:0]    u,
  output logic                  reset_lfsr,
  output logic                  running,
  output logic [LEVEL_BITS-1:0] fifo_level,
  output logic                  underrun,
  output logic [7:0]            underrun_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEVEL_BITS-1:0] DEPTH_L = LEVEL_BITS'(DEPTH);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t              state;
  logic [IN_BITS-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [OSR_BITS-1:0] hold_cnt;
  logic [LEVEL_BITS-1:0] thr;
  logic empty, push, pop, prime_go, run_slot, underrun_ev;

  always_comb begin
    empty       = (fifo_level == '0);
    in_ready    = (fifo_level != DEPTH_L);
    thr         = (prime_level > DEPTH_L) ? DEPTH_L : prime_level;
    prime_go    = (state == PRIME) && (fifo_level >= thr);
    run_slot    = (state == RUN) && pulse_done && (hold_cnt == '0);
    push        = in_valid && in_ready && !stop;
    pop         = !stop && !empty && (prime_go || run_slot);
    underrun_ev = !stop && run_slot && empty;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      hold_cnt   <= '0;
      u          <= '0;
      reset_lfsr <= 1'b0;
      running    <= 1'b0;
    end else if (stop) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      hold_cnt   <= '0;
      u          <= '0;
      reset_lfsr <= 1'b0;
      running    <= 1'b0;
    end else begin
      reset_lfsr <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      case (state)
        IDLE: begin
          u        <= '0;
          hold_cnt <= '0;
          if (start) begin
            state      <= PRIME;
            reset_lfsr <= 1'b1;
          end
        end
        PRIME: begin
          if (prime_go) begin
            state   <= RUN;
            running <= 1'b1;
            // prime_level=0 may enter RUN empty; hold 0 lets the first pulse_done retry
            if (!empty) begin
              u        <= mem[rd_ptr];
              hold_cnt <= osr;
            end else begin
              hold_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (pulse_done) begin
            if (hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;
            else if (!empty) begin
              u        <= mem[rd_ptr];
              hold_cnt <= osr;
            end else if (underrun_zero) u <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A same-cycle underrun wins over clear_status so the event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (underrun_ev) begin
      underrun <= 1'b1;
      if (clear_status)                 underrun_count <= 8'd1;
      else if (underrun_count != 8'hFF) underrun_count <= underrun_count + 1'b1;
    end else if (clear_status) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end
  end
endmodule

// File: doc/ds_sample_feeder.md
# ds_sample_feeder

Input-side sequencer for `delta_sigma_pw_modulator`. It buffers host samples in a small FIFO and holds each one on the modulator's `u` input for a programmable number of PWM periods (oversampling ratio). It advances on the modulator's `pulse_done` and runs an IDLE/PRIME/RUN state machine that primes the FIFO and re-seeds the LFSR on start. It also reports FIFO level and underruns.

## Interface
- `IN_BITS`, 16, sample width; matches modulator `u`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `OSR_BITS`, 8, width of hold-count configuration.
- `LEVEL_BITS`, $clog2(DEPTH)+1, derived; width of level and prime threshold.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request, IDLE→PRIME.
- `stop` in 1: one-cycle request, any state→IDLE.
- `osr` in OSR_BITS: each sample is held for `osr`+1 `pulse_done` events.
- `prime_level` in LEVEL_BITS: FIFO entries required before RUN; values >DEPTH saturate to DEPTH.
- `underrun_zero` in 1: on underrun, 1 drives `u`=0; 0 repeats the last `u`.
- `clear_status` in 1: clears `underrun` and `underrun_count`.
- `in_valid` in 1, `in_data` in IN_BITS, `in_ready` out 1: push handshake.
- `pulse_done` in 1: from the modulator, one cycle per PWM period.
- `u` out IN_BITS: modulator input, registered.
- `reset_lfsr` out 1: registered one-cycle pulse to the modulator.
- `running` out 1: high in RUN.
- `fifo_level` out LEVEL_BITS: current occupancy, 0..DEPTH.
- `underrun` out 1: sticky flag.
- `underrun_count` out 8: saturating count of underrun events.

## Operation
- Push handshake:
  - `in_ready` = !full; it is combinational on level only and does not depend on a same-cycle pop.
  - A push occurs when `in_valid && in_ready`. Pushes are accepted in every state, including IDLE (prefill).
  - A push and a pop in the same cycle leave the level unchanged. The FIFO uses wrap-around read/write pointers with an explicit level counter.
- State machine, states IDLE, PRIME and RUN:
  - IDLE: `u` is held at 0 and `hold_cnt` at 0. `start` moves to PRIME and pulses `reset_lfsr` for the next cycle.
  - PRIME: when `fifo_level` ≥ min(`prime_level`, DEPTH), move to RUN on the same evaluation. `prime_level`=0 passes through PRIME in one cycle.
  - PRIME→RUN transition cycle: pop the head into `u` and set `hold_cnt`=`osr`. `pulse_done` in that cycle is ignored.
  - RUN, on `pulse_done` with `hold_cnt`>0: decrement `hold_cnt`; `u` is unchanged.
  - RUN, on `pulse_done` with `hold_cnt`=0 and the FIFO non-empty: pop into `u`, set `hold_cnt`=`osr`.
  - RUN, on `pulse_done` with `hold_cnt`=0 and the FIFO empty (underrun): set `u` to 0 if `underrun_zero`, otherwise keep it. Set `underrun`, increment `underrun_count` saturating at 255, keep `hold_cnt`=0 so the next `pulse_done` retries the pop.
  - `stop` (any state): go to IDLE, `u`←0, flush the FIFO (level 0, pointers equal). A push in the same cycle is discarded.
- Priorities:
  - `stop` beats `start`.
  - `start` outside IDLE is ignored.
  - An underrun event in the same cycle as `clear_status` leaves `underrun`=1 and `underrun_count`=1.
- `osr` and `underrun_zero` are sampled at use; a change takes effect at the next reload or underrun.

## Timing
- Values after `rst_n` low:
  - Outputs: `u`=0, `reset_lfsr`=0, `running`=0, `fifo_level`=0, `underrun`=0, `underrun_count`=0; `in_ready`=1.
  - State: IDLE.
- Asserting `rst_n` mid-RUN returns the block to IDLE immediately and discards FIFO contents.
- `start` seen at edge N: state=PRIME and `reset_lfsr`=1 during cycle N+1; `reset_lfsr`=0 from N+2.
- PRIME→RUN: `running` and the new `u` appear 1 cycle after the edge at which the level condition is sampled true.
- `pulse_done` at edge N: updated `u` is visible from N+1, and `fifo_level` decrements at N+1.
- `u` changes only at pops, underruns (when `underrun_zero`=1), and `stop`/reset. It is stable between `pulse_done` events, as the modulator requires.
- Throughput: 1 push per cycle; at most 1 pop per `pulse_done`.

## Test plan
- Prefill and start:
  - Stimulus: in IDLE push 0x1111, 0x2222; `prime_level`=2, `osr`=0; pulse `start`.
  - Required: `reset_lfsr` high for exactly 1 cycle; `running` rises; `u`=0x1111.
  - Next `pulse_done`: `u`=0x2222; `fifo_level`=0.
- Oversampling hold:
  - Stimulus: `osr`=3, 2 samples queued.
  - Required: `u` changes only on every 4th `pulse_done`; the intermediate 3 leave `u` unchanged.
- Underrun:
  - Stimulus: FIFO empty in RUN, `underrun_zero`=0, `u`=0x1234; 3 `pulse_done`.
  - Required: `u` stays 0x1234; `underrun`=1; `underrun_count`=3.
  - Repeat with `underrun_zero`=1: `u`=0 after the first event.
  - Then push 0x5555: it appears on the next `pulse_done`.
- Full FIFO:
  - Stimulus: push 5 with DEPTH=4 in IDLE.
  - Required: `in_ready`=0 after 4 pushes; level=4; the 5th sample is held by the source.
  - Simultaneous push and pop at level 4 in RUN is not possible (`in_ready`=0). At level 3, a simultaneous push and pop keeps level 3.
- Stop and priority:
  - Stimulus: `start`+`stop` in the same cycle from IDLE → stays IDLE, no `reset_lfsr` pulse.
  - Stimulus: `stop` mid-RUN with level 2 → next cycle IDLE, `u`=0, level=0.
  - Stimulus: `clear_status` coinciding with an underrun → `underrun_count`=1.
- Async reset:
  - Stimulus: drop `rst_n` between clock edges mid-RUN.
  - Required: all outputs reach reset values without a clock edge; 255+ underruns saturate `underrun_count` at 255.
